// File: rtl/memory8x32_arbiter_if.sv
// Request/response bundle between two requesters and memory8x32_arbiter.
//
// Each port pX carries one valid/ready request channel and one response channel:
//   pX_valid, pX_wr, pX_addr, pX_wdata  requester -> arbiter
//   pX_ready                            arbiter -> requester (combinational accept)
//   pX_rsp_valid, pX_rsp_rdata          arbiter -> requester (one-cycle response pulse)
// Modports: master = requester side, slave = arbiter side.
interface memory8x32_arbiter_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned AW    = 3
);
  logic             p0_valid;
  logic             p0_ready;
  logic             p0_wr;
  logic [AW-1:0]    p0_addr;
  logic [WIDTH-1:0] p0_wdata;
  logic             p0_rsp_valid;
  logic [WIDTH-1:0] p0_rsp_rdata;

  logic             p1_valid;
  logic             p1_ready;
  logic             p1_wr;
  logic [AW-1:0]    p1_addr;
  logic [WIDTH-1:0] p1_wdata;
  logic             p1_rsp_valid;
  logic [WIDTH-1:0] p1_rsp_rdata;

  modport master (
    output p0_valid, p0_wr, p0_addr, p0_wdata,
    input  p0_ready, p0_rsp_valid, p0_rsp_rdata,
    output p1_valid, p1_wr, p1_addr, p1_wdata,
    input  p1_ready, p1_rsp_valid, p1_rsp_rdata
  );

  modport slave (
    input  p0_valid, p0_wr, p0_addr, p0_wdata,
    output p0_ready, p0_rsp_valid, p0_rsp_rdata,
    input  p1_valid, p1_wr, p1_addr, p1_wdata,
    output p1_ready, p1_rsp_valid, p1_rsp_rdata
  );
endinterface

// File: rtl/memory8x32_arbiter.sv
// Two-port arbiter and sequencer in front of the 8 x 32 D-FF register memory.
// One request per cycle is granted across both ports. Writes go through a one-entry
// write stage (ws) that drives the memory write port. Reads come from the memory's
// parallel outputs, with forwarding from ws. A bulk-clear sequencer zeroes all words.
//
// Ports:
//   clk, resetn         clock, asynchronous active-low reset (shared with the memory)
//   bus (slave)         two request/response ports, see memory8x32_arbiter_if
//   clr_start           bulk-clear request (pulse or level)
//   clr_busy, clr_done  clear active / one-cycle completion pulse
//   mem_we, mem_wen,    memory write enable, one-hot word enable, write data
//   mem_wd
//   mem_reg             parallel register contents from the memory
//
// Build option: define MEMARB_RR_EN for round-robin arbitration; otherwise port 0 has
// fixed priority.
module memory8x32_arbiter #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 32,
  parameter int unsigned AW    = 3
) (
  input  logic                         clk,
  input  logic                         resetn,
  memory8x32_arbiter_if.slave          bus,
  input  logic                         clr_start,
  output logic                         clr_busy,
  output logic                         clr_done,
  output logic                         mem_we,
  output logic [DEPTH-1:0]             mem_wen,
  output logic [WIDTH-1:0]             mem_wd,
  input  logic [DEPTH-1:0][WIDTH-1:0]  mem_reg
);

  typedef enum logic {StIdle, StClear} state_e;

  state_e           state_q;
  logic [AW-1:0]    ccnt_q;
  logic             ws_valid_q;
  logic [AW-1:0]    ws_addr_q;
  logic [WIDTH-1:0] ws_data_q;
  logic             rsp0_valid_q, rsp1_valid_q;
  logic [WIDTH-1:0] rsp0_rdata_q, rsp1_rdata_q;
  logic             clr_done_q;
`ifdef MEMARB_RR_EN
  logic             last_q;  // port granted most recently
`endif

  logic             gnt0, gnt1;
  logic             req_wr;
  logic [AW-1:0]    req_addr;
  logic [WIDTH-1:0] req_wdata;
  logic [WIDTH-1:0] req_rdata;

  // Grant at most one port; clear wins over requests in the same cycle.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (resetn && (state_q == StIdle) && !clr_start) begin
`ifdef MEMARB_RR_EN
      if (bus.p0_valid && bus.p1_valid) begin
        gnt0 = last_q;
        gnt1 = !last_q;
      end else begin
        gnt0 = bus.p0_valid;
        gnt1 = bus.p1_valid;
      end
`else
      gnt0 = bus.p0_valid;
      gnt1 = bus.p1_valid && !bus.p0_valid;
`endif
    end
  end

  always_comb begin
    req_wr    = gnt1 ? bus.p1_wr    : bus.p0_wr;
    req_addr  = gnt1 ? bus.p1_addr  : bus.p0_addr;
    req_wdata = gnt1 ? bus.p1_wdata : bus.p0_wdata;
    // A write in ws commits on the same edge this read is answered, so mem_reg is stale.
    if (req_wr) begin
      req_rdata = '0;
    end else if (ws_valid_q && (ws_addr_q == req_addr)) begin
      req_rdata = ws_data_q;
    end else begin
      req_rdata = mem_reg[req_addr];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= StIdle;
      ccnt_q       <= '0;
      ws_valid_q   <= 1'b0;
      ws_addr_q    <= '0;
      ws_data_q    <= '0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_rdata_q <= '0;
      rsp1_rdata_q <= '0;
      clr_done_q   <= 1'b0;
`ifdef MEMARB_RR_EN
      last_q       <= 1'b1;
`endif
    end else begin
      ws_valid_q   <= 1'b0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      clr_done_q   <= 1'b0;
      case (state_q)
        StIdle: begin
          if (clr_start) begin
            state_q <= StClear;
            ccnt_q  <= '0;
          end else if (gnt0 || gnt1) begin
            if (req_wr) begin
              ws_valid_q <= 1'b1;
              ws_addr_q  <= req_addr;
              ws_data_q  <= req_wdata;
            end
            if (gnt0) begin
              rsp0_valid_q <= 1'b1;
              rsp0_rdata_q <= req_rdata;
            end else begin
              rsp1_valid_q <= 1'b1;
              rsp1_rdata_q <= req_rdata;
            end
`ifdef MEMARB_RR_EN
            last_q <= gnt1;
`endif
          end
        end
        StClear: begin
          ws_valid_q <= 1'b1;
          ws_addr_q  <= ccnt_q;
          ws_data_q  <= '0;
          ccnt_q     <= ccnt_q + AW'(1);
          if (ccnt_q == AW'(DEPTH - 1)) begin
            state_q    <= StIdle;
            clr_done_q <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    mem_wen = '0;
    if (ws_valid_q) mem_wen[ws_addr_q] = 1'b1;
  end

  assign mem_we           = ws_valid_q;
  assign mem_wd           = ws_data_q;
  assign clr_busy         = (state_q == StClear);
  assign clr_done         = clr_done_q;
  assign bus.p0_ready     = gnt0;
  assign bus.p1_ready     = gnt1;
  assign bus.p0_rsp_valid = rsp0_valid_q;
  assign bus.p1_rsp_valid = rsp1_valid_q;
  assign bus.p0_rsp_rdata = rsp0_rdata_q;
  assign bus.p1_rsp_rdata = rsp1_rdata_q;

endmodule

// File: tb/tb_memory8x32_arbiter.sv
// Self-checking bench for memory8x32_arbiter: directed scenarios plus a randomized run
// checked against a transaction-level model (word array, grant rule, clear timer).
module tb_memory8x32_arbiter;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned WIDTH = 32;
  localparam int unsigned AW    = 3;

  logic                        clk = 1'b0;
  logic                        resetn = 1'b0;
  logic                        clr_start = 1'b0;
  logic                        clr_busy, clr_done, mem_we;
  logic [DEPTH-1:0]            mem_wen;
  logic [WIDTH-1:0]            mem_wd;
  logic [DEPTH-1:0][WIDTH-1:0] mem_q;

  int checks = 0;
  int passes = 0;
  logic [WIDTH-1:0] ref_mem [DEPTH];
  int model_last;

  memory8x32_arbiter_if #(.WIDTH(WIDTH), .AW(AW)) bus ();

  memory8x32_arbiter #(.DEPTH(DEPTH), .WIDTH(WIDTH), .AW(AW)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .bus       (bus),
    .clr_start (clr_start),
    .clr_busy  (clr_busy),
    .clr_done  (clr_done),
    .mem_we    (mem_we),
    .mem_wen   (mem_wen),
    .mem_wd    (mem_wd),
    .mem_reg   (mem_q)
  );

  // The 8 x 32 register memory the arbiter drives, reset by the same net.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) if (mem_we && mem_wen[i]) mem_q[i] <= mem_wd;
    end
  end

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int p, input logic v, input logic wr, input logic [AW-1:0] a,
                       input logic [WIDTH-1:0] d);
    if (p == 0) begin
      bus.p0_valid = v; bus.p0_wr = wr; bus.p0_addr = a; bus.p0_wdata = d;
    end else begin
      bus.p1_valid = v; bus.p1_wr = wr; bus.p1_addr = a; bus.p1_wdata = d;
    end
  endtask

  task automatic idle_inputs();
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    clr_start = 1'b0;
  endtask

  task automatic apply_reset();
    resetn = 1'b0;
    idle_inputs();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    model_last = 1;
    tick();
    tick();
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    idle_inputs();
    #2;
    checks++;
    if ({mem_we, mem_wen, mem_wd} !== '0)
      $display("FAIL reset_mem_port: got we=%b wen=%h wd=%h want all 0", mem_we, mem_wen, mem_wd);
    else passes++;
    checks++;
    if ({clr_busy, clr_done} !== 2'b00)
      $display("FAIL reset_clr: got busy=%b done=%b want 0 0", clr_busy, clr_done);
    else passes++;
    checks++;
    if ({bus.p0_ready, bus.p1_ready, bus.p0_rsp_valid, bus.p1_rsp_valid} !== 4'b0)
      $display("FAIL reset_handshake: got rdy=%b%b rsp=%b%b want 0", bus.p0_ready, bus.p1_ready,
               bus.p0_rsp_valid, bus.p1_rsp_valid);
    else passes++;
    checks++;
    if ({bus.p0_rsp_rdata, bus.p1_rsp_rdata} !== '0)
      $display("FAIL reset_rdata: got %h %h want 0", bus.p0_rsp_rdata, bus.p1_rsp_rdata);
    else passes++;
    apply_reset();
  endtask

  task automatic test_write_read();
    tick();
    drive(0, 1'b1, 1'b1, AW'(3), 32'hDEAD_BEEF);
    #1;
    checks++;
    if (bus.p0_ready !== 1'b1) $display("FAIL wr_ready: got %b want 1", bus.p0_ready);
    else passes++;
    tick();
    idle_inputs();
    checks++;
    if ({mem_we, mem_wen, mem_wd} !== {1'b1, 8'h08, 32'hDEAD_BEEF})
      $display("FAIL wr_mem_port: got we=%b wen=%h wd=%h want 1 08 deadbeef", mem_we, mem_wen,
               mem_wd);
    else passes++;
    checks++;
    if ({bus.p0_rsp_valid, bus.p0_rsp_rdata} !== {1'b1, 32'h0})
      $display("FAIL wr_rsp: got v=%b d=%h want 1 0", bus.p0_rsp_valid, bus.p0_rsp_rdata);
    else passes++;
    tick();
    checks++;
    if ({mem_we, bus.p0_rsp_valid} !== 2'b00)
      $display("FAIL wr_pulse: got we=%b rsp=%b want 0 0", mem_we, bus.p0_rsp_valid);
    else passes++;
    tick();
    drive(0, 1'b1, 1'b0, AW'(3), '0);
    #1;
    checks++;
    if (bus.p0_ready !== 1'b1) $display("FAIL rd_ready: got %b want 1", bus.p0_ready);
    else passes++;
    tick();
    idle_inputs();
    checks++;
    if ({bus.p0_rsp_valid, bus.p0_rsp_rdata} !== {1'b1, 32'hDEAD_BEEF})
      $display("FAIL rd_rsp: got v=%b d=%h want 1 deadbeef", bus.p0_rsp_valid, bus.p0_rsp_rdata);
    else passes++;
  endtask

  task automatic test_contention();
    int idx[2];
    int got;
    int exp;
    apply_reset();
    idx[0] = 0;
    idx[1] = 0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      drive(0, idx[0] < 4, 1'b1, AW'(idx[0]), 32'hA000_0000 + idx[0]);
      drive(1, idx[1] < 4, 1'b1, AW'(4 + idx[1]), 32'hB000_0000 + idx[1]);
      #1;
      got = bus.p0_ready ? 0 : (bus.p1_ready ? 1 : -1);
`ifdef MEMARB_RR_EN
      exp = cyc % 2;
`else
      exp = (cyc < 4) ? 0 : 1;
`endif
      checks++;
      if (got != exp) $display("FAIL contention_grant[%0d]: got port %0d want port %0d", cyc, got, exp);
      else passes++;
      if (got >= 0) idx[got]++;
      tick();
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_forwarding();
    drive(0, 1'b1, 1'b1, AW'(5), 32'h1234_5678);
    #1;
    checks++;
    if (bus.p0_ready !== 1'b1) $display("FAIL fwd_wr_ready: got %b want 1", bus.p0_ready);
    else passes++;
    tick();
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b1, 1'b0, AW'(5), '0);
    #1;
    checks++;
    if (bus.p1_ready !== 1'b1) $display("FAIL fwd_rd_ready: got %b want 1", bus.p1_ready);
    else passes++;
    tick();
    idle_inputs();
    checks++;
    if ({bus.p1_rsp_valid, bus.p1_rsp_rdata} !== {1'b1, 32'h1234_5678})
      $display("FAIL fwd_rsp: got v=%b d=%h want 1 12345678", bus.p1_rsp_valid, bus.p1_rsp_rdata);
    else passes++;
    tick();
  endtask

  task automatic test_bulk_clear();
    int done_cnt;
    logic [DEPTH-1:0] exp_wen;
    logic exp_we;
    done_cnt = 0;
    for (int a = 0; a < DEPTH; a++) begin
      drive(0, 1'b1, 1'b1, AW'(a), 32'hFFFF_FFFF);
      #1;
      checks++;
      if (bus.p0_ready !== 1'b1) $display("FAIL preload_ready[%0d]: got %b want 1", a, bus.p0_ready);
      else passes++;
      tick();
    end
    idle_inputs();
    tick();
    tick();
    checks++;
    if (mem_q !== '1) $display("FAIL preload_mem: got %h want all ones", mem_q);
    else passes++;
    clr_start = 1'b1;
    drive(0, 1'b1, 1'b0, AW'(7), '0);
    #1;
    checks++;
    if (bus.p0_ready !== 1'b0) $display("FAIL clr_start_ready: got %b want 0", bus.p0_ready);
    else passes++;
    for (int k = 1; k <= 9; k++) begin
      tick();
      clr_start = 1'b0;
      #1;
      if (clr_done === 1'b1) done_cnt++;
      exp_we  = (k >= 2);
      exp_wen = (k >= 2) ? (DEPTH'(1) << (k - 2)) : '0;
      checks++;
      if (clr_busy !== (k <= 8)) $display("FAIL clr_busy[%0d]: got %b want %b", k, clr_busy, k <= 8);
      else passes++;
      checks++;
      if (bus.p0_ready !== (k == 9))
        $display("FAIL clr_ready[%0d]: got %b want %b", k, bus.p0_ready, k == 9);
      else passes++;
      checks++;
      if ({mem_we, mem_wen} !== {exp_we, exp_wen})
        $display("FAIL clr_wen[%0d]: got we=%b wen=%h want %b %h", k, mem_we, mem_wen, exp_we,
                 exp_wen);
      else passes++;
      checks++;
      if (clr_done !== (k == 9)) $display("FAIL clr_done[%0d]: got %b want %b", k, clr_done, k == 9);
      else passes++;
    end
    tick();
    idle_inputs();
    checks++;
    if ({bus.p0_rsp_valid, bus.p0_rsp_rdata} !== {1'b1, 32'h0})
      $display("FAIL clr_fwd_rsp: got v=%b d=%h want 1 0", bus.p0_rsp_valid, bus.p0_rsp_rdata);
    else passes++;
    checks++;
    if (done_cnt != 1) $display("FAIL clr_done_count: got %0d want 1", done_cnt);
    else passes++;
    checks++;
    if (mem_q !== '0) $display("FAIL clr_mem: got %h want all 0", mem_q);
    else passes++;
    tick();
  endtask

  task automatic test_reset_mid_clear();
    drive(0, 1'b1, 1'b1, AW'(6), 32'hFFFF_FFFF);
    tick();
    idle_inputs();
    tick();
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    tick();
    tick();
    checks++;
    if (clr_busy !== 1'b1) $display("FAIL midclr_busy: got %b want 1", clr_busy);
    else passes++;
    resetn = 1'b0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    model_last = 1;
    #1;
    checks++;
    if ({clr_busy, clr_done, mem_we, mem_wen, mem_wd} !== '0)
      $display("FAIL midclr_reset_out: got busy=%b done=%b we=%b wen=%h wd=%h want all 0",
               clr_busy, clr_done, mem_we, mem_wen, mem_wd);
    else passes++;
    tick();
    resetn = 1'b1;
    drive(0, 1'b1, 1'b0, AW'(6), '0);
    #1;
    checks++;
    if ({bus.p0_ready, clr_busy} !== 2'b10)
      $display("FAIL midclr_after_ready: got rdy=%b busy=%b want 1 0", bus.p0_ready, clr_busy);
    else passes++;
    tick();
    idle_inputs();
    checks++;
    if ({bus.p0_rsp_valid, bus.p0_rsp_rdata} !== {1'b1, 32'h0})
      $display("FAIL midclr_after_rsp: got v=%b d=%h want 1 0", bus.p0_rsp_valid, bus.p0_rsp_rdata);
    else passes++;
    tick();
  endtask

  task automatic test_random();
    bit               pend[2];
    logic             pwr[2];
    logic [AW-1:0]    paddr[2];
    logic [WIDTH-1:0] pdata[2];
    bit               exp_v[2];
    logic [WIDTH-1:0] exp_d[2];
    logic             got_v[2];
    logic [WIDTH-1:0] got_d[2];
    int               clr_left;
    bit               clr;
    bit               exp_done;
    int               gnt;
    apply_reset();
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    clr_left = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && ($urandom_range(0, 2) != 0)) begin
          pend[p]  = 1'b1;
          pwr[p]   = 1'($urandom_range(0, 1));
          paddr[p] = AW'($urandom_range(0, DEPTH - 1));
          pdata[p] = $urandom;
        end
        drive(p, pend[p], pwr[p], paddr[p], pdata[p]);
      end
      clr = (clr_left == 0) && ($urandom_range(0, 49) == 0);
      clr_start = clr;
      #1;
      // Model: blocked while clearing or when a clear starts; else grant rule.
      gnt = -1;
      if (clr_left == 0 && !clr) begin
`ifdef MEMARB_RR_EN
        if (pend[0] && pend[1]) gnt = (model_last == 1) ? 0 : 1;
`else
        if (pend[0] && pend[1]) gnt = 0;
`endif
        else if (pend[0]) gnt = 0;
        else if (pend[1]) gnt = 1;
      end
      checks++;
      if (bus.p0_ready !== (gnt == 0))
        $display("FAIL rand_p0_ready[%0d]: got %b want %b", cyc, bus.p0_ready, gnt == 0);
      else passes++;
      checks++;
      if (bus.p1_ready !== (gnt == 1))
        $display("FAIL rand_p1_ready[%0d]: got %b want %b", cyc, bus.p1_ready, gnt == 1);
      else passes++;
      checks++;
      if (clr_busy !== (clr_left > 0))
        $display("FAIL rand_busy[%0d]: got %b want %b", cyc, clr_busy, clr_left > 0);
      else passes++;
      exp_v[0] = 1'b0;
      exp_v[1] = 1'b0;
      if (gnt >= 0) begin
        exp_v[gnt] = 1'b1;
        exp_d[gnt] = pwr[gnt] ? '0 : ref_mem[paddr[gnt]];
        if (pwr[gnt]) ref_mem[paddr[gnt]] = pdata[gnt];
        pend[gnt]  = 1'b0;
        model_last = gnt;
      end
      exp_done = 1'b0;
      if (clr) begin
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        clr_left = DEPTH;
      end else if (clr_left > 0) begin
        clr_left--;
        if (clr_left == 0) exp_done = 1'b1;
      end
      tick();
      got_v[0] = bus.p0_rsp_valid;
      got_v[1] = bus.p1_rsp_valid;
      got_d[0] = bus.p0_rsp_rdata;
      got_d[1] = bus.p1_rsp_rdata;
      for (int p = 0; p < 2; p++) begin
        checks++;
        if (got_v[p] !== exp_v[p])
          $display("FAIL rand_rsp_valid[%0d] p%0d: got %b want %b", cyc, p, got_v[p], exp_v[p]);
        else passes++;
        if (exp_v[p]) begin
          checks++;
          if (got_d[p] !== exp_d[p])
            $display("FAIL rand_rdata[%0d] p%0d: got %h want %h", cyc, p, got_d[p], exp_d[p]);
          else passes++;
        end
      end
      checks++;
      if (clr_done !== exp_done)
        $display("FAIL rand_done[%0d]: got %b want %b", cyc, clr_done, exp_done);
      else passes++;
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_contention();
    test_forwarding();
    test_bulk_clear();
    test_reset_mid_clear();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/memory8x32_arbiter.md
# memory8x32_arbiter

Two-port request arbiter and sequencer for the 8 x 32 D-FF register memory. It takes read/write requests from two independent requesters over valid/ready handshakes and grants one per cycle. Granted writes drive the memory's write-enable, one-hot word-enable and write-data inputs. Reads are served from the memory's parallel register outputs, with forwarding from the in-flight write. A bulk-clear sequencer zeroes all eight words without software loops.

## Interface
- `DEPTH`, 8: number of memory words. Fixed to match the memory.
- `WIDTH`, 32: data width.
- `AW`, 3: address width. Equals log2(`DEPTH`).
- `clk` in 1: single clock. Everything is rising-edge.
- `resetn` in 1: asynchronous, active-low reset. The same net resets the memory.
- `p0_valid`, `p1_valid` in 1: request valid, per port.
- `p0_ready`, `p1_ready` out 1: request accepted this cycle. Combinational.
- `p0_wr`, `p1_wr` in 1: 1 = write, 0 = read.
- `p0_addr`, `p1_addr` in `AW`: word address.
- `p0_wdata`, `p1_wdata` in `WIDTH`: write data.
- `p0_rsp_valid`, `p1_rsp_valid` out 1: one-cycle response pulse. Sent for both reads and writes.
- `p0_rsp_rdata`, `p1_rsp_rdata` out `WIDTH`: read data. Zero for write responses.
- `clr_start` in 1: bulk-clear request. A pulse or a level is accepted.
- `clr_busy` out 1: high while the clear sequencer is active.
- `clr_done` out 1: one-cycle pulse when the clear completes.
- `mem_we` out 1: memory write enable.
- `mem_wen` out `DEPTH`: one-hot word enable.
- `mem_wd` out `WIDTH`: memory write data.
- `mem_reg` in `DEPTH` x `WIDTH`: parallel register contents from the memory.

## Operation
- **States:** IDLE and CLEAR. A 3-bit clear counter `ccnt` runs in CLEAR.
- **Write stage register `ws`:** holds `valid`, `addr` and `data`.
  - `mem_we = ws.valid`.
  - `mem_wen = ws.valid ? (1 << ws.addr) : 0`.
  - `mem_wd = ws.data`.
  - `ws.valid` clears each cycle unless it is reloaded.
- **IDLE:**
  - If `clr_start` is high, both readies are 0 and the next state is CLEAR with `ccnt = 0`. Clear beats requests in the same cycle.
  - Otherwise the arbiter grants at most one valid port. `pX_ready = grant_X`.
  - Arbitration order is set by `MEMARB_RR_EN` (see Configuration).
- **Accepted write:** `ws <= {1, addr, wdata}`. Also `pX_rsp_valid <= 1` and `pX_rsp_rdata <= 0`.
- **Accepted read:**
  - `pX_rsp_rdata <= (ws.valid && ws.addr == addr) ? ws.data : mem_reg[addr]`.
  - `pX_rsp_valid <= 1`.
  - The forward is required because a write committing on the same edge is not yet visible on `mem_reg`.
- **CLEAR:**
  - Readies are 0. `clr_start` is ignored.
  - Each cycle: `ws <= {1, ccnt, 0}` and `ccnt++`.
  - At `ccnt == 7`: go to IDLE and set `clr_done <= 1`.
  - `clr_busy = (state == CLEAR)`.
- **Round-robin pointer `last`:** updates only on a grant. Reset value is 1, so port 0 wins the first contention.
- **Address range:** addresses are `AW` bits, so all values are in range and there is no wrap or error case.

## Timing
- **Reset values:** every output is 0, state is IDLE, `ws.valid = 0` and `last = 1`. Reset is asynchronous and can occur mid-CLEAR or mid-write. The sequence is abandoned, nothing is replayed, and the memory is reset by the same `resetn`.
- **Write accepted in cycle N:**
  - `mem_we`/`mem_wen`/`mem_wd` are valid in N+1.
  - The memory captures at the edge ending N+1.
  - `rsp_valid` is high in N+1.
- **Read accepted in cycle N:** `rsp_valid` and `rsp_rdata` are valid in N+1. Latency is 1.
- **Throughput:** one request per cycle total, across both ports.
- **Back-to-back write then read, same address:** write accepted in N, read accepted in N+1. The read returns the write data in N+2 via forwarding.
- **`clr_start` sampled in IDLE in cycle N:**
  - Clear writes to addresses 0..7 appear in N+2..N+9.
  - `clr_done` is high in N+9.
  - Requests can be accepted again from N+9. A read of address 7 in N+9 forwards 0.
- **Handshake rules:**
  - A requester holds `valid` and its payload stable until `ready`.
  - `ready` never depends on `rsp_valid`.

## Configuration
- **`MEMARB_RR_EN` defined:** round-robin arbitration.
  - On contention, grant the port not equal to `last`.
  - With a single requester, grant it.
- **`MEMARB_RR_EN` undefined:** fixed priority.
  - Port 0 always wins contention.
  - `last` is not implemented.
  - Port 1 may starve.

## Test plan
- **Single write then read:** after reset, p0 writes addr 3 = 0xDEADBEEF.
  - Expect `mem_wen = 0x08`, `mem_we = 1` and `p0_rsp_valid` one cycle later.
  - A p0 read of addr 3 issued later returns 0xDEADBEEF.
- **Contention with `MEMARB_RR_EN`:** both ports hold valid writes, 4 each, for 8 cycles.
  - Grants alternate p0, p1, p0, p1 and so on, starting with p0.
  - Without the macro, all four p0 writes are granted before any p1 write.
- **Forwarding:** p0 writes addr 5 = 0x12345678 in cycle N; p1 reads addr 5 in N+1.
  - `p1_rsp_rdata` = 0x12345678 in N+2.
- **Bulk clear:** preload all 8 words with 0xFFFFFFFF, then pulse `clr_start` with p0 valid in the same cycle.
  - p0 is not ready until `clr_done`.
  - `mem_wen` steps 0x01 → 0x80 over 8 cycles.
  - `clr_done` pulses once, and all `mem_reg` words read 0.
- **Reset mid-clear:** assert `resetn` = 0 at the third clear cycle.
  - Outputs go to 0 immediately and the state returns to IDLE.
  - After release, the first p0 request is accepted with 1-cycle latency.
